nastilite_reg_slice: RTL and testbench



---
 rtl/nastilite_reg_slice_if.sv | 40 ++++
 rtl/nastilite_reg_slice.sv | 168 ++++++++++++++++
 tb/tb_nastilite_reg_slice.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nastilite_reg_slice_if.sv
// NASTILite configuration-path bundle: AW, W, B, AR and R channels.
// The master drives requests and accepts responses; the slave is the mirror image.
interface nasti_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/nastilite_reg_slice.sv
// Full register slice for the NASTILite configuration path: every channel goes
// through an independent 2-entry skid buffer so no valid/ready path is combinational.

module nastilite_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  // Encoding chosen so bit 0 is the main-register valid and bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_data_next;
  logic [WIDTH-1:0] k_data;
  logic [WIDTH-1:0] k_data_next;
  logic             ready_q;
  logic             acc;
  logic             take;

  assign acc       = in_valid & ready_q;
  assign take      = state[0] & out_ready;
  assign out_valid = state[0];
  assign in_ready  = ready_q;
  assign out_data  = m_data;

  always_comb begin
    state_next  = state;
    m_data_next = m_data;
    k_data_next = k_data;
    case (state)
      EMPTY: begin
        if (acc) begin
          m_data_next = in_data;
          state_next  = ONE;
        end
      end
      ONE: begin
        if (acc && take) begin
          m_data_next = in_data;
        end else if (acc) begin
          k_data_next = in_data;
          state_next  = FULL;
        end else if (take) begin
          state_next  = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          m_data_next = k_data;
          state_next  = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // ready_q resets low and tracks "skid empty" from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      m_data  <= '0;
      k_data  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      m_data  <= m_data_next;
      k_data  <= k_data_next;
      ready_q <= (state_next != FULL);
    end
  end
endmodule

module nastilite_reg_slice #(
  parameter int C_NASTI_ADDR_WIDTH = 5,
  parameter int C_NASTI_DATA_WIDTH = 64
) (
  input  logic    s_nastilite_clk,
  input  logic    s_nastilite_aresetn,
  nasti_if.slave  s_nastilite,
  nasti_if.master m_nastilite
);
  localparam int STRB_WIDTH = C_NASTI_DATA_WIDTH / 8;
  localparam int W_WIDTH    = C_NASTI_DATA_WIDTH + STRB_WIDTH;
  localparam int R_WIDTH    = C_NASTI_DATA_WIDTH + 2;

  logic [C_NASTI_ADDR_WIDTH-1:0] aw_out;
  logic [C_NASTI_ADDR_WIDTH-1:0] ar_out;
  logic [W_WIDTH-1:0]            w_out;
  logic [R_WIDTH-1:0]            r_out;
  logic [1:0]                    b_out;

  nastilite_skid_slice #(.WIDTH(C_NASTI_ADDR_WIDTH)) aw_slice (
    .clk       (s_nastilite_clk),
    .rst_n     (s_nastilite_aresetn),
    .in_valid  (s_nastilite.aw_valid),
    .in_ready  (s_nastilite.aw_ready),
    .in_data   (s_nastilite.aw_addr),
    .out_valid (m_nastilite.aw_valid),
    .out_ready (m_nastilite.aw_ready),
    .out_data  (aw_out)
  );

  nastilite_skid_slice #(.WIDTH(W_WIDTH)) w_slice (
    .clk       (s_nastilite_clk),
    .rst_n     (s_nastilite_aresetn),
    .in_valid  (s_nastilite.w_valid),
    .in_ready  (s_nastilite.w_ready),
    .in_data   ({s_nastilite.w_data, s_nastilite.w_strb}),
    .out_valid (m_nastilite.w_valid),
    .out_ready (m_nastilite.w_ready),
    .out_data  (w_out)
  );

  nastilite_skid_slice #(.WIDTH(C_NASTI_ADDR_WIDTH)) ar_slice (
    .clk       (s_nastilite_clk),
    .rst_n     (s_nastilite_aresetn),
    .in_valid  (s_nastilite.ar_valid),
    .in_ready  (s_nastilite.ar_ready),
    .in_data   (s_nastilite.ar_addr),
    .out_valid (m_nastilite.ar_valid),
    .out_ready (m_nastilite.ar_ready),
    .out_data  (ar_out)
  );

  // Response channels run the other way: downstream frontend in, interconnect out.
  nastilite_skid_slice #(.WIDTH(2)) b_slice (
    .clk       (s_nastilite_clk),
    .rst_n     (s_nastilite_aresetn),
    .in_valid  (m_nastilite.b_valid),
    .in_ready  (m_nastilite.b_ready),
    .in_data   (m_nastilite.b_resp),
    .out_valid (s_nastilite.b_valid),
    .out_ready (s_nastilite.b_ready),
    .out_data  (b_out)
  );

  nastilite_skid_slice #(.WIDTH(R_WIDTH)) r_slice (
    .clk       (s_nastilite_clk),
    .rst_n     (s_nastilite_aresetn),
    .in_valid  (m_nastilite.r_valid),
    .in_ready  (m_nastilite.r_ready),
    .in_data   ({m_nastilite.r_data, m_nastilite.r_resp}),
    .out_valid (s_nastilite.r_valid),
    .out_ready (s_nastilite.r_ready),
    .out_data  (r_out)
  );

  assign m_nastilite.aw_addr = aw_out;
  assign m_nastilite.ar_addr = ar_out;
  assign m_nastilite.w_data  = w_out[W_WIDTH-1:STRB_WIDTH];
  assign m_nastilite.w_strb  = w_out[STRB_WIDTH-1:0];
  assign s_nastilite.b_resp  = b_out;
  assign s_nastilite.r_data  = r_out[R_WIDTH-1:2];
  assign s_nastilite.r_resp  = r_out[1:0];
endmodule

// File: tb/tb_nastilite_reg_slice.sv
// Directed bench for nastilite_reg_slice: per-channel scoreboard queues filled on
// input handshakes and drained on output handshakes, plus directed step checks.
module tb_nastilite_reg_slice;
  logic clk;
  logic aresetn;
  int   errors;
  int   checks;

  nasti_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) s_bus ();
  nasti_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) m_bus ();

  nastilite_reg_slice #(
    .C_NASTI_ADDR_WIDTH (5),
    .C_NASTI_DATA_WIDTH (64)
  ) dut (
    .s_nastilite_clk     (clk),
    .s_nastilite_aresetn (aresetn),
    .s_nastilite         (s_bus),
    .m_nastilite         (m_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
  logic [4:0]  in_fire;
  logic [4:0]  out_fire;
  logic [4:0]  out_vld;
  logic [4:0]  out_rdy;
  logic [71:0] in_pay  [5];
  logic [71:0] out_pay [5];
  logic [71:0] exp_q   [5][$];
  logic [4:0]  prev_stall;
  logic [71:0] prev_pay [5];

  assign in_fire[0] = s_bus.aw_valid & s_bus.aw_ready;
  assign in_fire[1] = s_bus.w_valid  & s_bus.w_ready;
  assign in_fire[2] = m_bus.b_valid  & m_bus.b_ready;
  assign in_fire[3] = s_bus.ar_valid & s_bus.ar_ready;
  assign in_fire[4] = m_bus.r_valid  & m_bus.r_ready;
  assign in_pay[0]  = 72'(s_bus.aw_addr);
  assign in_pay[1]  = {s_bus.w_data, s_bus.w_strb};
  assign in_pay[2]  = 72'(m_bus.b_resp);
  assign in_pay[3]  = 72'(s_bus.ar_addr);
  assign in_pay[4]  = 72'({m_bus.r_data, m_bus.r_resp});

  assign out_vld = {s_bus.r_valid, m_bus.ar_valid, s_bus.b_valid, m_bus.w_valid, m_bus.aw_valid};
  assign out_rdy = {s_bus.r_ready, m_bus.ar_ready, s_bus.b_ready, m_bus.w_ready, m_bus.aw_ready};
  assign out_fire = out_vld & out_rdy;
  assign out_pay[0] = 72'(m_bus.aw_addr);
  assign out_pay[1] = {m_bus.w_data, m_bus.w_strb};
  assign out_pay[2] = 72'(s_bus.b_resp);
  assign out_pay[3] = 72'(m_bus.ar_addr);
  assign out_pay[4] = 72'({s_bus.r_data, s_bus.r_resp});

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] want_v);
    checks++;
    assert (obs === want_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] readies();
    return {s_bus.aw_ready, s_bus.w_ready, s_bus.ar_ready, m_bus.b_ready, m_bus.r_ready};
  endfunction

  // Mid-cycle monitor: check held outputs, pop expected beats on take, push on accept.
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = '0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (prev_stall[c]) begin
          chk($sformatf("hold_valid_ch%0d", c), 72'(out_vld[c]), 72'(1));
          chk($sformatf("hold_payload_ch%0d", c), out_pay[c], prev_pay[c]);
        end
        if (out_fire[c]) begin
          logic have;
          have = (exp_q[c].size() > 0);
          chk($sformatf("beat_expected_ch%0d", c), 72'(have), 72'(1));
          if (have) chk($sformatf("beat_payload_ch%0d", c), out_pay[c], exp_q[c].pop_front());
        end
        if (in_fire[c]) exp_q[c].push_back(in_pay[c]);
        prev_stall[c] = out_vld[c] & ~out_rdy[c];
        prev_pay[c]   = out_pay[c];
      end
    end
  end

  initial begin
    int idx;
    int occ;
    int low;
    logic fire;
    logic take;

    errors = 0;
    checks = 0;
    prev_stall = '0;
    aresetn = 1'b0;
    s_bus.aw_valid = 1'b1; s_bus.aw_addr = 5'h08;
    s_bus.w_valid = 1'b0;  s_bus.w_data = '0; s_bus.w_strb = '0;
    s_bus.ar_valid = 1'b0; s_bus.ar_addr = '0;
    s_bus.b_ready = 1'b0;  s_bus.r_ready = 1'b0;
    m_bus.aw_ready = 1'b0; m_bus.w_ready = 1'b0; m_bus.ar_ready = 1'b0;
    m_bus.b_valid = 1'b0;  m_bus.b_resp = '0;
    m_bus.r_valid = 1'b0;  m_bus.r_data = '0; m_bus.r_resp = '0;

    // Reset held for five cycles with a pending AW request.
    repeat (5) begin
      tick();
      chk("reset_readies", 72'(readies()), 72'(0));
      chk("reset_valids", 72'(out_vld), 72'(0));
    end
    aresetn = 1'b1;
    tick();
    chk("release_readies", 72'(readies()), 72'(5'b11111));
    chk("release_aw_not_yet", 72'(m_bus.aw_valid), 72'(0));
    tick();
    chk("first_aw_valid", 72'(m_bus.aw_valid), 72'(1));
    chk("first_aw_addr", 72'(m_bus.aw_addr), 72'(5'h08));
    s_bus.aw_valid = 1'b0;
    tick();
    chk("first_aw_held", 72'(m_bus.aw_valid), 72'(1));
    m_bus.aw_ready = 1'b1;
    tick();
    chk("first_aw_drained", 72'(m_bus.aw_valid), 72'(0));

    // Sixteen back-to-back W beats at full rate.
    m_bus.w_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_bus.w_valid = 1'b1;
      s_bus.w_data  = 64'(i);
      s_bus.w_strb  = 8'hFF;
      chk("stream_w_ready", 72'(s_bus.w_ready), 72'(1));
      tick();
      chk("stream_w_valid", 72'(m_bus.w_valid), 72'(1));
      chk("stream_w_data", 72'(m_bus.w_data), 72'(i));
    end
    s_bus.w_valid = 1'b0;
    tick();
    chk("stream_w_drained", 72'(m_bus.w_valid), 72'(0));

    // AR stream 0..7 with downstream ready low on cycles 3-5.
    idx = 0; occ = 0; low = 0;
    for (int cyc = 0; cyc < 40 && !(idx == 8 && occ == 0); cyc++) begin
      m_bus.ar_ready = !(cyc >= 3 && cyc <= 5);
      s_bus.ar_valid = (idx < 8);
      s_bus.ar_addr  = 5'(idx);
      chk("ar_ready_vs_occupancy", 72'(s_bus.ar_ready), 72'(occ != 2));
      if (!s_bus.ar_ready) low++;
      fire = s_bus.ar_valid & s_bus.ar_ready;
      take = m_bus.ar_valid & m_bus.ar_ready;
      if (fire) idx++;
      occ = occ + int'(fire) - int'(take);
      tick();
    end
    s_bus.ar_valid = 1'b0;
    m_bus.ar_ready = 1'b1;
    chk("ar_all_sent", 72'(idx), 72'(8));
    chk("ar_all_taken", 72'(occ), 72'(0));
    chk("ar_ready_low_cycles", 72'(low), 72'(3));
    chk("ar_drained", 72'(m_bus.ar_valid), 72'(0));

    // AW leads its W by three cycles; then two write responses come back.
    s_bus.b_ready = 1'b1;
    s_bus.aw_valid = 1'b1; s_bus.aw_addr = 5'h10;
    tick();
    s_bus.aw_valid = 1'b0;
    chk("indep_aw_valid", 72'(m_bus.aw_valid), 72'(1));
    chk("indep_aw_addr", 72'(m_bus.aw_addr), 72'(5'h10));
    chk("indep_w_idle", 72'(m_bus.w_valid), 72'(0));
    tick();
    tick();
    s_bus.w_valid = 1'b1; s_bus.w_data = 64'hDEAD_BEEF_0000_0001; s_bus.w_strb = 8'hFF;
    tick();
    s_bus.w_valid = 1'b0;
    chk("indep_w_valid", 72'(m_bus.w_valid), 72'(1));
    chk("indep_w_data", 72'(m_bus.w_data), 72'(64'hDEAD_BEEF_0000_0001));
    chk("indep_aw_idle", 72'(m_bus.aw_valid), 72'(0));
    m_bus.b_valid = 1'b1; m_bus.b_resp = 2'b00;
    tick();
    chk("b_first_valid", 72'(s_bus.b_valid), 72'(1));
    chk("b_first_resp", 72'(s_bus.b_resp), 72'(2'b00));
    m_bus.b_resp = 2'b10;
    tick();
    m_bus.b_valid = 1'b0;
    chk("b_second_resp", 72'(s_bus.b_resp), 72'(2'b10));
    tick();
    chk("b_drained", 72'(s_bus.b_valid), 72'(0));

    // Read response held off upstream for four cycles while the skid fills.
    s_bus.r_ready = 1'b0;
    m_bus.r_valid = 1'b1; m_bus.r_data = 64'hA5A5; m_bus.r_resp = 2'b00;
    tick();
    chk("r_stall_valid", 72'(s_bus.r_valid), 72'(1));
    chk("r_stall_data", 72'(s_bus.r_data), 72'(64'hA5A5));
    chk("r_ready_before_full", 72'(m_bus.r_ready), 72'(1));
    m_bus.r_data = 64'h5A5A; m_bus.r_resp = 2'b01;
    tick();
    m_bus.r_valid = 1'b0;
    chk("r_ready_full", 72'(m_bus.r_ready), 72'(0));
    repeat (2) begin
      tick();
      chk("r_stall_hold", 72'(s_bus.r_data), 72'(64'hA5A5));
    end
    s_bus.r_ready = 1'b1;
    tick();
    chk("r_second_data", 72'(s_bus.r_data), 72'(64'h5A5A));
    chk("r_second_resp", 72'(s_bus.r_resp), 72'(2'b01));
    chk("r_ready_recovered", 72'(m_bus.r_ready), 72'(1));
    tick();
    chk("r_drained", 72'(s_bus.r_valid), 72'(0));

    // Fill W and R, then reset asynchronously in mid-cycle.
    m_bus.w_ready = 1'b0; s_bus.r_ready = 1'b0;
    s_bus.w_valid = 1'b1; s_bus.w_data = 64'h11;
    m_bus.r_valid = 1'b1; m_bus.r_data = 64'h33;
    tick();
    s_bus.w_data = 64'h22; m_bus.r_data = 64'h44;
    tick();
    s_bus.w_valid = 1'b0; m_bus.r_valid = 1'b0;
    chk("full_w_ready", 72'(s_bus.w_ready), 72'(0));
    chk("full_r_ready", 72'(m_bus.r_ready), 72'(0));
    #1 aresetn = 1'b0;
    #1;
    chk("async_reset_valids", 72'(out_vld), 72'(0));
    chk("async_reset_readies", 72'(readies()), 72'(0));
    for (int c = 0; c < 5; c++) exp_q[c].delete();
    m_bus.w_ready = 1'b1; s_bus.r_ready = 1'b1;
    tick();
    aresetn = 1'b1;
    repeat (4) begin
      tick();
      chk("no_stale_beat", 72'(out_vld), 72'(0));
    end

    for (int c = 0; c < 5; c++)
      chk($sformatf("queue_empty_ch%0d", c), 72'(exp_q[c].size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
